ahb_slave_mem: RTL and testbench

AHB-Lite responder model: the slave end of the AHB interface driven by our AHB master test driver. It accepts NONSEQ/SEQ transfers, stores write data in an internal word array, returns read data, inserts a programmable number of wait states, and issues the two-cycle ERROR response for out-of-range addresses. It serves as the stand-alone target for checking master sequences before the bridge is connected, and as the reference responder in bridge comparison benches.

---
 rtl/ahb_slave_mem.sv | 164 ++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb_slave_mem
//   AHB-Lite responder backed by a 2^ADDR_W x 32-bit word array. Accepts
//   NONSEQ/SEQ transfers, inserts WAIT_STATES wait cycles per OKAY data phase
//   and answers addresses outside [BASE, BASE + 2^ADDR_W) with the two-cycle
//   ERROR response. Every address value maps to its own word (no byte lanes).
//
// Ports
//   hclk       clock, all state changes on the rising edge
//   hresetn    asynchronous active-low reset
//   hwrite     1 = write, 0 = read (sampled only at accept)
//   hreadyin   bus HREADY, high when the previous data phase is complete
//   htrans     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   haddr      byte address
//   hwdata     write data, sampled at the final data-phase edge
//   hreadyout  low stretches the current data phase
//   hrdata     read data, held until the next read accept
//   hresp      00 OKAY, 01 ERROR
// ----------------------------------------------------------------------------
module ahb_slave_mem #(
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
  // Last counter value spent in WAIT; unused when there are no wait states.
  localparam logic [3:0]  WAIT_LAST = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          wait_cnt_r;
  logic [3:0]          wait_cnt_s;
  logic                hwrite_r;
  logic [ADDR_W-1:0]   idx_r;
  logic                in_range_r;
  logic                hreadyout_r;
  logic [1:0]          hresp_r;
  logic [31:0]         hrdata_r;
  logic [31:0]         mem_r [DEPTH];

  logic [31:0]         offset_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   idx_s;
  logic                accept_s;
  logic                wr_commit_s;
  logic                fwd_s;

  // Unsigned subtraction: addresses below BASE wrap to huge offsets and
  // therefore fall out of range without a separate lower-bound compare.
  assign offset_s    = haddr - BASE;
  assign in_range_s  = (offset_s[31:ADDR_W] == '0);
  assign idx_s       = offset_s[ADDR_W-1:0];
  assign accept_s    = hreadyin & hreadyout_r & htrans[1];
  // A pending write lands at the edge that ends DATA; ERROR never reaches DATA.
  assign wr_commit_s = hresetn & (state_r == ST_DATA) & hwrite_r & in_range_r;
  // Read accepted at the same edge a write to the same word completes.
  assign fwd_s       = wr_commit_s & (idx_r == idx_s);

  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign hrdata    = hrdata_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = 4'd0;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (!in_range_s) begin
            state_s = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_DATA;
        end else begin
          state_s    = ST_WAIT;
          wait_cnt_s = wait_cnt_r + 4'd1;
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, registered handshake outputs and address-phase capture.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 2'b00;
      hwrite_r    <= 1'b0;
      idx_r       <= '0;
      in_range_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      hreadyout_r <= !((state_s == ST_WAIT) || (state_s == ST_ERR1));
      hresp_r     <= ((state_s == ST_ERR1) || (state_s == ST_ERR2)) ? 2'b01 : 2'b00;
      if (accept_s) begin
        hwrite_r   <= hwrite;
        idx_r      <= idx_s;
        in_range_r <= in_range_s;
      end
    end
  end

  // Read data register: loaded at a read accept, held otherwise.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata_r <= 32'd0;
    end else if (accept_s && !hwrite) begin
      if (!in_range_s) begin
        hrdata_r <= 32'd0;
      end else if (fwd_s) begin
        hrdata_r <= hwdata;
      end else begin
        hrdata_r <= mem_r[idx_s];
      end
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge hclk) begin
    if (wr_commit_s) begin
      mem_r[idx_r] <= hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mem
//   Drives three responders (0, 2 and 3 wait states) from one pipelined AHB
//   master. Only the selected responder sees NONSEQ/SEQ; the others see IDLE.
//   Expected responses are queued when a transfer is accepted and compared
//   when its data phase completes.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          ADDR_W = 13;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  typedef struct {
    logic        rd;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
    int          low;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htr [3];
  logic        hro [3];
  logic [1:0]  hrs [3];
  logic [31:0] hrd [3];
  logic        hready_m;
  int          sel;

  tx_t         txq [$];
  exp_t        expq [$];
  logic [31:0] model [int];
  int          ws_tab [3] = '{0, 2, 3};
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 hclk = ~hclk;

  assign htr[0]   = (sel == 0) ? htrans : 2'b00;
  assign htr[1]   = (sel == 1) ? htrans : 2'b00;
  assign htr[2]   = (sel == 2) ? htrans : 2'b00;
  assign hready_m = hro[sel];

  ahb_slave_mem #(.BASE(BASE), .ADDR_W(ADDR_W), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hro[0]),
    .htrans(htr[0]), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hro[0]), .hrdata(hrd[0]), .hresp(hrs[0]));

  ahb_slave_mem #(.BASE(BASE), .ADDR_W(ADDR_W), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hro[1]),
    .htrans(htr[1]), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hro[1]), .hrdata(hrd[1]), .hresp(hrs[1]));

  ahb_slave_mem #(.BASE(BASE), .ADDR_W(ADDR_W), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hro[2]),
    .htrans(htr[2]), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hro[2]), .hrdata(hrd[2]), .hresp(hrs[2]));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data);
    tx_t t;
    t.trans = trans;
    t.wr    = wr;
    t.addr  = addr;
    t.data  = data;
    txq.push_back(t);
  endtask

  // Pipelined master: entered and left at posedge+1.
  task automatic run_bus(input string tag);
    logic        dp_valid;
    logic [31:0] dp_wdata;
    int          dp_low;
    int          cyc;
    int          key;
    logic [31:0] off;
    tx_t         t;
    exp_t        e;
    dp_valid = 1'b0;
    dp_wdata = 32'd0;
    dp_low   = 0;
    cyc      = 0;
    while ((txq.size() > 0 || dp_valid) && cyc < 200) begin
      if (txq.size() > 0) begin
        htrans = txq[0].trans;
        hwrite = txq[0].wr;
        haddr  = txq[0].addr;
      end else begin
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
      end
      // Junk on hwdata during wait cycles must be ignored.
      hwdata = (dp_valid && hready_m) ? dp_wdata : $urandom;
      @(negedge hclk);
      if (dp_valid) begin
        if (!hready_m) begin
          dp_low++;
          check_val({tag, "_wait_resp"}, 32'(hrs[sel]), expq[0].err ? 32'd1 : 32'd0);
          if (expq[0].rd && expq[0].chk)
            check_val({tag, "_wait_rdata"}, hrd[sel], expq[0].rdata);
        end else begin
          e = expq.pop_front();
          check_val({tag, "_resp"}, 32'(hrs[sel]), e.err ? 32'd1 : 32'd0);
          check_val({tag, "_low_cycles"}, 32'(dp_low), 32'(e.low));
          if (e.rd && e.chk)
            check_val({tag, "_rdata"}, hrd[sel], e.rdata);
          dp_valid = 1'b0;
        end
      end
      if (hready_m && txq.size() > 0) begin
        t = txq.pop_front();
        if (t.trans[1]) begin
          off     = t.addr - BASE;
          key     = sel * (1 << ADDR_W) + int'(off[ADDR_W-1:0]);
          e.rd    = !t.wr;
          e.err   = (off >= 32'(1 << ADDR_W));
          e.low   = e.err ? 1 : ws_tab[sel];
          e.chk   = 1'b1;
          e.rdata = 32'd0;
          if (!e.err) begin
            if (t.wr) model[key] = t.data;
            else if (model.exists(key)) e.rdata = model[key];
            else e.chk = 1'b0;
          end
          expq.push_back(e);
          dp_valid = 1'b1;
          dp_wdata = t.data;
          dp_low   = 0;
        end
      end
      @(posedge hclk);
      #1;
      cyc++;
    end
    check_val({tag, "_outstanding"}, 32'(txq.size() + expq.size() + (dp_valid ? 1 : 0)), 32'd0);
    txq.delete();
    expq.delete();
    htrans = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d [4];
    logic [31:0] dfw;
    hresetn = 1'b0;
    sel     = 0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    haddr   = 32'h0;
    hwdata  = 32'h0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("reset_hready%0d", k), 32'(hro[k]), 32'd1);
      check_val($sformatf("reset_hresp%0d", k), 32'(hrs[k]), 32'd0);
      check_val($sformatf("reset_hrdata%0d", k), hrd[k], 32'd0);
    end
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Single write then read, IDLE gap between.
    add(2'b10, 1'b1, 32'h8000_0001, 32'h0000_0080);
    add(2'b00, 1'b0, 32'h0, 32'h0);
    add(2'b10, 1'b0, 32'h8000_0001, 32'h0);
    run_bus("single");

    // 4-beat burst write then burst read.
    for (int i = 0; i < 4; i++) d[i] = 32'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++)
      add((i == 0) ? 2'b10 : 2'b11, 1'b1, 32'h8000_1000 + 32'(i), d[i]);
    for (int i = 0; i < 4; i++)
      add((i == 0) ? 2'b10 : 2'b11, 1'b0, 32'h8000_1000 + 32'(i), 32'h0);
    run_bus("burst");

    // Back-to-back write/read of one word exercises forwarding.
    dfw = $urandom;
    add(2'b10, 1'b1, 32'h8000_0002, 32'h0000_1234);
    add(2'b00, 1'b0, 32'h0, 32'h0);
    add(2'b10, 1'b1, 32'h8000_0002, dfw);
    add(2'b10, 1'b0, 32'h8000_0002, 32'h0);
    run_bus("fwd");

    // Out-of-range and boundary addresses, plus BUSY/IDLE slots.
    add(2'b10, 1'b0, 32'h9000_0000, 32'h0);
    add(2'b10, 1'b0, 32'h8000_0001, 32'h0);
    add(2'b10, 1'b1, BASE + 32'h1FFF, 32'h0000_7777);
    add(2'b01, 1'b1, BASE, 32'hDEAD_0001);
    add(2'b10, 1'b0, BASE + 32'h1FFF, 32'h0);
    add(2'b10, 1'b1, BASE, 32'h0000_5555);
    add(2'b10, 1'b1, BASE + 32'h2000, 32'h0000_0BAD);
    add(2'b10, 1'b0, BASE, 32'h0);
    add(2'b10, 1'b0, BASE - 32'h1, 32'h0);
    add(2'b00, 1'b1, BASE, 32'hDEAD_0002);
    add(2'b10, 1'b0, BASE, 32'h0);
    run_bus("range");

    // Two wait states.
    sel = 1;
    add(2'b10, 1'b1, 32'h8000_0010, 32'h0000_00A5);
    add(2'b10, 1'b0, 32'h8000_0010, 32'h0);
    add(2'b10, 1'b0, 32'h8000_0010, 32'h0);
    run_bus("ws2");

    // Three wait states: known value first, then reset during a write.
    sel = 2;
    add(2'b10, 1'b1, 32'h8000_0020, 32'h0000_0022);
    run_bus("ws3_pre");
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = 32'h8000_0020;
    hwdata = 32'h0000_0011;
    @(posedge hclk);
    #1;
    check_val("rst_first_wait", 32'(hro[2]), 32'd0);
    htrans = 2'b00;
    @(posedge hclk);
    #2;
    check_val("rst_second_wait", 32'(hro[2]), 32'd0);
    hresetn = 1'b0;
    #1;
    check_val("rst_async_hready", 32'(hro[2]), 32'd1);
    check_val("rst_async_hresp", 32'(hrs[2]), 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    add(2'b10, 1'b0, 32'h8000_0020, 32'h0);
    run_bus("ws3_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
